// File: rtl/intersection_scheduler_if.sv
// Request and lamp bundle between the intersection controller and its environment.
// The controller takes the slave view; whoever raises requests takes the master view.
interface intersection_scheduler_if;
    logic       req_ns;
    logic       req_ew;
    logic       ns_R;
    logic       ns_G;
    logic       ns_Y;
    logic       ew_R;
    logic       ew_G;
    logic       ew_Y;
    logic [2:0] phase;
    logic       phase_start;

    modport master (
        output req_ns, req_ew,
        input  ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, phase, phase_start
    );

    modport slave (
        input  req_ns, req_ew,
        output ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, phase, phase_start
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-direction intersection controller: green/yellow/all-red sequencing with
// latched cross requests, minimum-green preemption and a maximum-green hard cap.
module intersection_scheduler #(
    parameter int CTR_W     = 10,
    parameter int GREEN_MIN = 256,
    parameter int GREEN_MAX = 512,
    parameter int YELLOW    = 128,
    parameter int ALLRED    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    intersection_scheduler_if.slave  bus
);

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] RED_TO_EW = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] RED_TO_NS = 3'd5;

    localparam logic [CTR_W-1:0] GMIN_LAST   = CTR_W'(GREEN_MIN - 1);
    localparam logic [CTR_W-1:0] GMAX_LAST   = CTR_W'(GREEN_MAX - 1);
    localparam logic [CTR_W-1:0] YELLOW_LAST = CTR_W'(YELLOW - 1);
    localparam logic [CTR_W-1:0] ALLRED_LAST = CTR_W'(ALLRED - 1);
    localparam logic [CTR_W-1:0] CTR_SAT     = {CTR_W{1'b1}};

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CTR_W-1:0] ctr_r;
    logic [CTR_W-1:0] ctr_next_s;
    logic             pend_ns_r;
    logic             pend_ew_r;
    logic             pend_ns_next_s;
    logic             pend_ew_next_s;
    logic             phase_start_r;
    logic             state_change_s;

    // State, counter, pending latches and phase-start flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= NS_GREEN;
            ctr_r         <= {CTR_W{1'b0}};
            pend_ns_r     <= 1'b0;
            pend_ew_r     <= 1'b0;
            phase_start_r <= 1'b1;
        end else begin
            state_r       <= next_state_s;
            ctr_r         <= ctr_next_s;
            pend_ns_r     <= pend_ns_next_s;
            pend_ew_r     <= pend_ew_next_s;
            phase_start_r <= state_change_s;
        end
    end

    // Next-state selection; a green only yields when the other side is waiting
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            NS_GREEN: begin
                if (pend_ew_r && ((ctr_r >= GMIN_LAST && !bus.req_ns) || ctr_r == GMAX_LAST))
                    next_state_s = NS_YELLOW;
                else
                    next_state_s = NS_GREEN;
            end
            NS_YELLOW: begin
                if (ctr_r == YELLOW_LAST) next_state_s = RED_TO_EW;
                else                      next_state_s = NS_YELLOW;
            end
            RED_TO_EW: begin
                if (ctr_r == ALLRED_LAST) next_state_s = EW_GREEN;
                else                      next_state_s = RED_TO_EW;
            end
            EW_GREEN: begin
                if (pend_ns_r && ((ctr_r >= GMIN_LAST && !bus.req_ew) || ctr_r == GMAX_LAST))
                    next_state_s = EW_YELLOW;
                else
                    next_state_s = EW_GREEN;
            end
            EW_YELLOW: begin
                if (ctr_r == YELLOW_LAST) next_state_s = RED_TO_NS;
                else                      next_state_s = EW_YELLOW;
            end
            RED_TO_NS: begin
                if (ctr_r == ALLRED_LAST) next_state_s = NS_GREEN;
                else                      next_state_s = RED_TO_NS;
            end
            default: next_state_s = RED_TO_NS;
        endcase
    end

    // Phase counter and request latches; entering a green drops that side's request
    always_comb begin
        state_change_s = (next_state_s != state_r);
        ctr_next_s     = ctr_r;
        pend_ns_next_s = pend_ns_r;
        pend_ew_next_s = pend_ew_r;

        if (state_change_s)        ctr_next_s = {CTR_W{1'b0}};
        else if (ctr_r == CTR_SAT) ctr_next_s = ctr_r;
        else                       ctr_next_s = ctr_r + {{(CTR_W-1){1'b0}}, 1'b1};

        if (next_state_s == NS_GREEN && state_r != NS_GREEN) pend_ns_next_s = 1'b0;
        else if (state_r != NS_GREEN && bus.req_ns)          pend_ns_next_s = 1'b1;
        else                                                 pend_ns_next_s = pend_ns_r;

        if (next_state_s == EW_GREEN && state_r != EW_GREEN) pend_ew_next_s = 1'b0;
        else if (state_r != EW_GREEN && bus.req_ew)          pend_ew_next_s = 1'b1;
        else                                                 pend_ew_next_s = pend_ew_r;
    end

    // Lamp decode from the state register; illegal codes show red on both heads
    always_comb begin
        bus.ns_R        = 1'b1;
        bus.ns_G        = 1'b0;
        bus.ns_Y        = 1'b0;
        bus.ew_R        = 1'b1;
        bus.ew_G        = 1'b0;
        bus.ew_Y        = 1'b0;
        bus.phase       = state_r;
        bus.phase_start = phase_start_r;
        case (state_r)
            NS_GREEN:  begin bus.ns_R = 1'b0; bus.ns_G = 1'b1; end
            NS_YELLOW: begin bus.ns_R = 1'b0; bus.ns_Y = 1'b1; end
            EW_GREEN:  begin bus.ew_R = 1'b0; bus.ew_G = 1'b1; end
            EW_YELLOW: begin bus.ew_R = 1'b0; bus.ew_Y = 1'b1; end
            default:   begin bus.ns_R = 1'b1; bus.ew_R = 1'b1; end
        endcase
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: phase timing, preemption, hard cap,
// request latching, async reset, illegal-state recovery and lamp invariants.
module tb_intersection_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   bad;
    logic started;

    intersection_scheduler_if bus ();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Lamp safety invariants sampled every cycle once the bench is running
    always @(negedge clk) begin
        if (started) begin
            check("never_both_nonred", {31'd0, bus.ns_R | bus.ew_R}, 32'd1);
            check("ns_one_lamp", {31'd0, $onehot({bus.ns_R, bus.ns_G, bus.ns_Y})}, 32'd1);
            check("ew_one_lamp", {31'd0, $onehot({bus.ew_R, bus.ew_G, bus.ew_Y})}, 32'd1);
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        started    = 1'b0;
        rst        = 1'b1;
        bus.req_ns = 1'b0;
        bus.req_ew = 1'b0;

        // Idle: NS holds green forever
        do_reset();
        started = 1'b1;
        check("rst_phase", {29'd0, bus.phase}, 32'd0);
        check("rst_pstart", {31'd0, bus.phase_start}, 32'd1);
        check("rst_ns_G", {31'd0, bus.ns_G}, 32'd1);
        check("rst_ew_R", {31'd0, bus.ew_R}, 32'd1);
        bad = 0;
        for (int i = 1; i <= 2000; i++) begin
            goto(i);
            if (bus.phase !== 3'd0 || bus.phase_start !== 1'b0 || bus.ns_G !== 1'b1 || bus.ew_R !== 1'b1)
                bad++;
        end
        check("idle_2000_bad_cycles", bad, 32'd0);

        // EW pulse at cycle 10: yellow after minimum green
        do_reset();
        goto(10);  bus.req_ew = 1'b1;
        goto(11);  bus.req_ew = 1'b0;
        goto(255); check("min_c255_phase", {29'd0, bus.phase}, 32'd0);
        check("min_c255_ns_G", {31'd0, bus.ns_G}, 32'd1);
        goto(256); check("min_c256_phase", {29'd0, bus.phase}, 32'd1);
        check("min_c256_pstart", {31'd0, bus.phase_start}, 32'd1);
        check("min_c256_ns_Y", {31'd0, bus.ns_Y}, 32'd1);
        goto(257); check("min_c257_pstart", {31'd0, bus.phase_start}, 32'd0);
        goto(383); check("min_c383_phase", {29'd0, bus.phase}, 32'd1);
        goto(384); check("min_c384_phase", {29'd0, bus.phase}, 32'd2);
        check("min_c384_pstart", {31'd0, bus.phase_start}, 32'd1);
        goto(415); check("min_c415_phase", {29'd0, bus.phase}, 32'd2);
        goto(416); check("min_c416_phase", {29'd0, bus.phase}, 32'd3);
        check("min_c416_ew_G", {31'd0, bus.ew_G}, 32'd1);
        check("min_c416_pstart", {31'd0, bus.phase_start}, 32'd1);

        // req_ns held: NS green ends on the 512-cycle cap
        do_reset();
        bus.req_ns = 1'b1;
        goto(10);  bus.req_ew = 1'b1;
        goto(11);  bus.req_ew = 1'b0;
        goto(300); check("cap_c300_phase", {29'd0, bus.phase}, 32'd0);
        goto(511); check("cap_c511_phase", {29'd0, bus.phase}, 32'd0);
        goto(512); check("cap_c512_phase", {29'd0, bus.phase}, 32'd1);
        check("cap_c512_pstart", {31'd0, bus.phase_start}, 32'd1);
        goto(639); check("cap_c639_phase", {29'd0, bus.phase}, 32'd1);
        goto(640); check("cap_c640_phase", {29'd0, bus.phase}, 32'd2);
        goto(672); check("cap_c672_phase", {29'd0, bus.phase}, 32'd3);
        check("cap_c672_ew_G", {31'd0, bus.ew_G}, 32'd1);
        bus.req_ns = 1'b0;

        // Late EW request: yellow two cycles after the request edge
        do_reset();
        goto(600); bus.req_ew = 1'b1;
        goto(601); bus.req_ew = 1'b0;
        check("late_c601_phase", {29'd0, bus.phase}, 32'd0);
        goto(602); check("late_c602_phase", {29'd0, bus.phase}, 32'd1);
        check("late_c602_pstart", {31'd0, bus.phase_start}, 32'd1);

        // Both requests on the edge entering EW green: EW dropped, NS latched
        goto(761); check("both_c761_phase", {29'd0, bus.phase}, 32'd2);
        bus.req_ns = 1'b1;
        bus.req_ew = 1'b1;
        goto(762); bus.req_ns = 1'b0;
        bus.req_ew = 1'b0;
        check("both_c762_phase", {29'd0, bus.phase}, 32'd3);
        check("both_pend_ew", {31'd0, dut.pend_ew_r}, 32'd0);
        check("both_pend_ns", {31'd0, dut.pend_ns_r}, 32'd1);
        goto(1017); check("both_c1017_phase", {29'd0, bus.phase}, 32'd3);
        goto(1018); check("both_c1018_phase", {29'd0, bus.phase}, 32'd4);
        check("both_c1018_ew_Y", {31'd0, bus.ew_Y}, 32'd1);

        // Latch EW during its yellow, then reset asynchronously mid-yellow
        goto(1045); bus.req_ew = 1'b1;
        goto(1046); bus.req_ew = 1'b0;
        goto(1050); check("ar_c1050_phase", {29'd0, bus.phase}, 32'd4);
        #2 rst = 1'b1;
        #1;
        check("ar_async_ns_G", {31'd0, bus.ns_G}, 32'd1);
        check("ar_async_ew_R", {31'd0, bus.ew_R}, 32'd1);
        check("ar_async_phase", {29'd0, bus.phase}, 32'd0);
        check("ar_async_pend_ns", {31'd0, dut.pend_ns_r}, 32'd0);
        check("ar_async_pend_ew", {31'd0, dut.pend_ew_r}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        check("ar_c0_pstart", {31'd0, bus.phase_start}, 32'd1);
        goto(300); check("ar_c300_phase_hold", {29'd0, bus.phase}, 32'd0);

        // Illegal state 6 recovers to RED_TO_NS, then NS green after all-red
        #1 force dut.state_r = 3'd6;
        #1 release dut.state_r;
        #1 check("ill_forced_phase", {29'd0, bus.phase}, 32'd6);
        goto(301); check("ill_c301_phase", {29'd0, bus.phase}, 32'd5);
        check("ill_c301_pstart", {31'd0, bus.phase_start}, 32'd1);
        goto(332); check("ill_c332_phase", {29'd0, bus.phase}, 32'd5);
        goto(333); check("ill_c333_phase", {29'd0, bus.phase}, 32'd0);
        check("ill_c333_ns_G", {31'd0, bus.ns_G}, 32'd1);

        goto(334);
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
